// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
// slave  : seen from the reservation station
// master : seen from the surrounding dispatch / CDB / ALU logic (or a bench)
interface alu_rs_if #(
  parameter int TYPE_BIT      = 4,
  parameter int ROB_INDEX_BIT = 4
);
  logic                     disp_valid;
  logic [TYPE_BIT-1:0]      disp_type;
  logic [31:0]              disp_vj;
  logic [31:0]              disp_vk;
  logic [ROB_INDEX_BIT-1:0] disp_qj;
  logic [ROB_INDEX_BIT-1:0] disp_qk;
  logic                     disp_qj_busy;
  logic                     disp_qk_busy;
  logic [ROB_INDEX_BIT-1:0] disp_rob_id;
  logic                     full;

  logic                     cdb_alu_ready;
  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id;
  logic [31:0]              cdb_alu_result;
  logic                     cdb_lsb_ready;
  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id;
  logic [31:0]              cdb_lsb_result;

  logic                     alu_req;
  logic [TYPE_BIT-1:0]      alu_type;
  logic [31:0]              alu_r1;
  logic [31:0]              alu_r2;
  logic [ROB_INDEX_BIT-1:0] alu_rob_id;

  modport slave (
    input  disp_valid, disp_type, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, disp_rob_id,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result,
    output full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
  );

  modport master (
    output disp_valid, disp_type, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, disp_rob_id,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_result,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_result,
    input  full, alu_req, alu_type, alu_r1, alu_r2, alu_rob_id
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch/JALR ops, wakes pending
// operands from the ALU and LSB CDB ports, issues one ready op per cycle.
// Optional macro RS_AGE_ORDER_EN: issue the oldest ready op relative to
// rob_head_in instead of the lowest-index one (adds port rob_head_in).
module alu_reservation_station #(
  parameter int RS_SIZE_BIT   = 3,
  parameter int TYPE_BIT      = 4,
  parameter int ROB_INDEX_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
`ifdef RS_AGE_ORDER_EN
  input  logic [ROB_INDEX_BIT-1:0] rob_head_in,
`endif
  alu_rs_if.slave                  bus
);
  localparam int RS_SIZE = 1 << RS_SIZE_BIT;
  localparam int RB      = ROB_INDEX_BIT;

  // Entry state; busy flags are control and take the reset, payload does not.
  logic [RS_SIZE-1:0]  r_busy;
  logic [RS_SIZE-1:0]  r_qj_busy;
  logic [RS_SIZE-1:0]  r_qk_busy;
  logic [TYPE_BIT-1:0] r_type [RS_SIZE];
  logic [31:0]         r_vj   [RS_SIZE];
  logic [31:0]         r_vk   [RS_SIZE];
  logic [RB-1:0]       r_qj   [RS_SIZE];
  logic [RB-1:0]       r_qk   [RS_SIZE];
  logic [RB-1:0]       r_rob  [RS_SIZE];

  logic [32:0]            w_wk_j [RS_SIZE];
  logic [32:0]            w_wk_k [RS_SIZE];
  logic [32:0]            w_dp_j;
  logic [32:0]            w_dp_k;
  logic [RS_SIZE-1:0]     w_cand;
  logic                   w_has_cand;
  logic [RS_SIZE_BIT-1:0] w_sel;
  logic [RS_SIZE_BIT-1:0] w_free_idx;
  logic                   w_full;
  logic                   w_issue;
  logic                   w_disp;

  // Operand snoop: returns {still_pending, value}. ALU port has priority.
  function automatic logic [32:0] snoop(
    input logic          pend,
    input logic [RB-1:0] q,
    input logic [31:0]   v,
    input logic          a_rdy,
    input logic [RB-1:0] a_id,
    input logic [31:0]   a_res,
    input logic          l_rdy,
    input logic [RB-1:0] l_id,
    input logic [31:0]   l_res
  );
    if (pend && a_rdy && (a_id == q))      return {1'b0, a_res};
    else if (pend && l_rdy && (l_id == q)) return {1'b0, l_res};
    else                                   return {pend, v};
  endfunction

  assign w_dp_j = snoop(bus.disp_qj_busy, bus.disp_qj, bus.disp_vj,
                        bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_result,
                        bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_result);
  assign w_dp_k = snoop(bus.disp_qk_busy, bus.disp_qk, bus.disp_vk,
                        bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_result,
                        bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_result);

  // Wakeup view of every stored operand against both CDB ports.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wk_j[i] = snoop(r_qj_busy[i], r_qj[i], r_vj[i],
                        bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_result,
                        bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_result);
      w_wk_k[i] = snoop(r_qk_busy[i], r_qk[i], r_vk[i],
                        bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_result,
                        bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_result);
    end
  end

  assign w_cand = r_busy & ~r_qj_busy & ~r_qk_busy;
  assign w_full = &r_busy;

`ifdef RS_AGE_ORDER_EN
  logic [RB-1:0] w_age [RS_SIZE];
  logic [RB-1:0] w_best_age;

  // Program-order distance of each entry from the ROB head (modular).
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_age[i] = r_rob[i] - rob_head_in;
    end
  end

  // Issue select: oldest ready entry.
  always_comb begin
    w_has_cand = 1'b0;
    w_sel      = '0;
    w_best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_cand[i] && (!w_has_cand || (w_age[i] < w_best_age))) begin
        w_has_cand = 1'b1;
        w_sel      = RS_SIZE_BIT'(i);
        w_best_age = w_age[i];
      end
    end
  end
`else
  // Issue select: lowest-index ready entry.
  always_comb begin
    w_has_cand = 1'b0;
    w_sel      = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_cand[i] && !w_has_cand) begin
        w_has_cand = 1'b1;
        w_sel      = RS_SIZE_BIT'(i);
      end
    end
  end
`endif

  // Dispatch target: lowest-index free entry of the pre-edge state.
  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = RS_SIZE_BIT'(i);
    end
  end

  assign w_issue = w_has_cand && rdy_in && !clear_in;
  assign w_disp  = bus.disp_valid && !w_full && rdy_in && !clear_in;

  assign bus.full       = w_full;
  assign bus.alu_req    = w_issue;
  assign bus.alu_type   = w_has_cand ? r_type[w_sel] : '0;
  assign bus.alu_r1     = w_has_cand ? r_vj[w_sel]   : '0;
  assign bus.alu_r2     = w_has_cand ? r_vk[w_sel]   : '0;
  assign bus.alu_rob_id = w_has_cand ? r_rob[w_sel]  : '0;

  // Control: allocate on dispatch, free on issue/flush, clear pending flags on wakeup.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy    <= '0;
      r_qj_busy <= '0;
      r_qk_busy <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_qj_busy[i] <= w_wk_j[i][32];
          r_qk_busy[i] <= w_wk_k[i][32];
          if (w_issue && (w_sel == RS_SIZE_BIT'(i))) r_busy[i] <= 1'b0;
          if (w_disp && (w_free_idx == RS_SIZE_BIT'(i))) begin
            r_busy[i]    <= 1'b1;
            r_qj_busy[i] <= w_dp_j[32];
            r_qk_busy[i] <= w_dp_k[32];
          end
        end
      end
    end
  end

  // Payload: written on dispatch (with same-cycle forwarding), updated on wakeup.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_disp && (w_free_idx == RS_SIZE_BIT'(i))) begin
          r_type[i] <= bus.disp_type;
          r_vj[i]   <= w_dp_j[31:0];
          r_vk[i]   <= w_dp_k[31:0];
          r_qj[i]   <= bus.disp_qj;
          r_qk[i]   <= bus.disp_qk;
          r_rob[i]  <= bus.disp_rob_id;
        end else begin
          r_vj[i]   <= w_wk_j[i][31:0];
          r_vk[i]   <= w_wk_k[i][31:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a model.
module tb_alu_reservation_station;
  localparam int TB = 4;
  localparam int RB = 4;
  localparam int N  = 8;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic clr;
`ifdef RS_AGE_ORDER_EN
  logic [RB-1:0] rob_head;
`endif

  always #5 clk = ~clk;

  alu_rs_if #(.TYPE_BIT(TB), .ROB_INDEX_BIT(RB)) bus ();

  alu_reservation_station #(.RS_SIZE_BIT(3), .TYPE_BIT(TB), .ROB_INDEX_BIT(RB)) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .rdy_in      (rdy),
    .clear_in    (clr),
`ifdef RS_AGE_ORDER_EN
    .rob_head_in (rob_head),
`endif
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int dv, typ, vj, vk, qj, qk, qjb, qkb, rob;
    int ca, caid, cares, cl, clid, clres;
    int efull, ereq, etyp, e1, e2, erob;
  } vec_t;

  // ---------------- reference model (slot array, spec rules) ----------------
  bit          m_busy [N];
  int          m_typ  [N];
  logic [31:0] m_vj   [N];
  logic [31:0] m_vk   [N];
  int          m_qj   [N];
  int          m_qk   [N];
  bit          m_qjb  [N];
  bit          m_qkb  [N];
  int          m_rob  [N];

  function automatic int m_pick();
    int best;
`ifdef RS_AGE_ORDER_EN
    int ba, a;
    ba = 0;
`endif
    best = -1;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && !m_qjb[i] && !m_qkb[i]) begin
`ifdef RS_AGE_ORDER_EN
        a = (m_rob[i] - int'(rob_head)) % (1 << RB);
        if (a < 0) a = a + (1 << RB);
        if (best < 0 || a < ba) begin best = i; ba = a; end
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic bit m_is_full();
    int cnt = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) cnt++;
    return cnt == N;
  endfunction

  task automatic m_wake(inout bit b, input int q, inout logic [31:0] v);
    if (b) begin
      if (bus.cdb_alu_ready && int'(bus.cdb_alu_rob_id) == q) begin v = bus.cdb_alu_result; b = 1'b0; end
      else if (bus.cdb_lsb_ready && int'(bus.cdb_lsb_rob_id) == q) begin v = bus.cdb_lsb_result; b = 1'b0; end
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic m_edge();
    int iss, slot;
    bit f, b;
    logic [31:0] v;
    if (!rdy) return;
    if (clr) begin m_reset(); return; end
    iss  = m_pick();
    f    = m_is_full();
    slot = -1;
    for (int i = 0; i < N; i++) if (!m_busy[i] && slot < 0) slot = i;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        b = m_qjb[i]; v = m_vj[i]; m_wake(b, m_qj[i], v); m_qjb[i] = b; m_vj[i] = v;
        b = m_qkb[i]; v = m_vk[i]; m_wake(b, m_qk[i], v); m_qkb[i] = b; m_vk[i] = v;
      end
    end
    if (iss >= 0) m_busy[iss] = 1'b0;
    if (bus.disp_valid && !f) begin
      m_busy[slot] = 1'b1;
      m_typ[slot]  = int'(bus.disp_type);
      m_qj[slot]   = int'(bus.disp_qj);
      m_qk[slot]   = int'(bus.disp_qk);
      m_rob[slot]  = int'(bus.disp_rob_id);
      b = bus.disp_qj_busy; v = bus.disp_vj; m_wake(b, m_qj[slot], v); m_qjb[slot] = b; m_vj[slot] = v;
      b = bus.disp_qk_busy; v = bus.disp_vk; m_wake(b, m_qk[slot], v); m_qkb[slot] = b; m_vk[slot] = v;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int efull, input int ereq, input int etyp,
                         input logic [31:0] e1, input logic [31:0] e2, input int erob);
    chk({nm, ".full"}, 32'(bus.full), 32'(efull));
    chk({nm, ".req"},  32'(bus.alu_req), 32'(ereq));
    if (ereq != 0) begin
      chk({nm, ".type"}, 32'(bus.alu_type), 32'(etyp));
      chk({nm, ".r1"},   bus.alu_r1, e1);
      chk({nm, ".r2"},   bus.alu_r2, e2);
      chk({nm, ".rob"},  32'(bus.alu_rob_id), 32'(erob));
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1;
    clr = 1'b0;
    bus.disp_valid = 1'b0;   bus.disp_type = '0;
    bus.disp_vj = '0;        bus.disp_vk = '0;
    bus.disp_qj = '0;        bus.disp_qk = '0;
    bus.disp_qj_busy = 1'b0; bus.disp_qk_busy = 1'b0;
    bus.disp_rob_id = '0;
    bus.cdb_alu_ready = 1'b0; bus.cdb_alu_rob_id = '0; bus.cdb_alu_result = '0;
    bus.cdb_lsb_ready = 1'b0; bus.cdb_lsb_rob_id = '0; bus.cdb_lsb_result = '0;
  endtask

  task automatic set_disp(input int typ, input int vj, input int vk, input int qj, input int qk,
                          input int qjb, input int qkb, input int rob);
    bus.disp_valid = 1'b1;
    bus.disp_type = 4'(typ);
    bus.disp_vj = 32'(vj);   bus.disp_vk = 32'(vk);
    bus.disp_qj = 4'(qj);    bus.disp_qk = 4'(qk);
    bus.disp_qj_busy = (qjb != 0); bus.disp_qk_busy = (qkb != 0);
    bus.disp_rob_id = 4'(rob);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_reset();
  endtask

  vec_t vec [14];
  int exp_i, ei, ereq;

  initial begin
    rst_n = 1'b0;
`ifdef RS_AGE_ORDER_EN
    rob_head = '0;
`endif
    idle_inputs();
    tick();
    tick();
    // reset state
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.r1",   bus.alu_r1, 32'd0);
    chk("reset.rob",  32'(bus.alu_rob_id), 32'd0);
    chk("reset.type", 32'(bus.alu_type), 32'd0);
    rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    //           dv typ vj vk qj qk qjb qkb rob  ca caid cares  cl clid clres  full req etyp e1 e2 erob
    vec[0]  = '{1, OP_ADD, 3, 4, 0, 0, 0, 0, 2,   0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 1, OP_ADD, 3, 4, 2};
    vec[2]  = '{1, OP_SUB, 0, 1, 5, 0, 1, 0, 3,   0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        1, 4, 99,     0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      1, 3, 77,     0, 0, 0, 0, 0, 0};
    vec[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      1, 5, 10,     0, 0, 0, 0, 0, 0};
    vec[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 1, OP_SUB, 10, 1, 3};
    vec[7]  = '{1, OP_AND, 9, 0, 0, 6, 0, 1, 4,   1, 6, 'h55,   0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 1, OP_AND, 9, 'h55, 4};
    vec[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[10] = '{1, OP_ADD, 1, 2, 0, 0, 0, 0, 7,   0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0};
    vec[11] = '{1, OP_ADD, 5, 6, 0, 0, 0, 0, 8,   0, 0, 0,      0, 0, 0,      0, 1, OP_ADD, 1, 2, 7};
    vec[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 1, OP_ADD, 5, 6, 8};
    vec[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 14; k++) begin
      idle_inputs();
      if (vec[k].dv != 0)
        set_disp(vec[k].typ, vec[k].vj, vec[k].vk, vec[k].qj, vec[k].qk, vec[k].qjb, vec[k].qkb, vec[k].rob);
      bus.cdb_alu_ready = (vec[k].ca != 0);
      bus.cdb_alu_rob_id = 4'(vec[k].caid);
      bus.cdb_alu_result = 32'(vec[k].cares);
      bus.cdb_lsb_ready = (vec[k].cl != 0);
      bus.cdb_lsb_rob_id = 4'(vec[k].clid);
      bus.cdb_lsb_result = 32'(vec[k].clres);
      #2;
      chk_out($sformatf("vec%0d", k), vec[k].efull, vec[k].ereq, vec[k].etyp,
              32'(vec[k].e1), 32'(vec[k].e2), vec[k].erob);
      tick();
    end

    // ---------------- freeze, then asynchronous reset with 5 busy ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); set_disp(OP_SUB, k, 0, 1, 0, 1, 0, k + 1); tick();
    end
    idle_inputs(); set_disp(OP_ADD, 'h11, 'h22, 0, 0, 0, 0, 9); tick();
    idle_inputs();
    rdy = 1'b0;
    set_disp(OP_ADD, 'h33, 'h44, 0, 0, 0, 0, 12);
    bus.cdb_alu_ready = 1'b1; bus.cdb_alu_rob_id = 4'd1; bus.cdb_alu_result = 32'hAA;
    #2;
    chk_out("freeze", 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    #2;
    chk_out("after_freeze", 0, 1, OP_ADD, 32'h11, 32'h22, 9);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst.r1",  bus.alu_r1, 32'd0);
    chk("async_rst.r2",  bus.alu_r2, 32'd0);
    chk("async_rst.rob", 32'(bus.alu_rob_id), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.cdb_alu_ready = 1'b1; bus.cdb_alu_rob_id = 4'd1; bus.cdb_alu_result = 32'h5;
    #2;
    chk_out("post_rst0", 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    #2;
    chk_out("post_rst1", 0, 0, 0, 0, 0, 0);
    m_reset();

    // ---------------- fill, drop on full, clear ----------------
    for (int k = 0; k < 8; k++) begin
      idle_inputs(); set_disp(OP_ADD, k, k, 15, 0, 1, 0, k); tick();
    end
    idle_inputs();
    #2;
    chk_out("filled", 1, 0, 0, 0, 0, 0);
    set_disp(OP_ADD, 1, 2, 0, 0, 0, 0, 14);
    tick();
    idle_inputs();
    #2;
    chk_out("drop", 1, 0, 0, 0, 0, 0);
    clr = 1'b1;
    bus.cdb_alu_ready = 1'b1; bus.cdb_alu_rob_id = 4'd15; bus.cdb_alu_result = 32'h1;
    #2;
    chk_out("clear_cyc", 1, 0, 0, 0, 0, 0);
    tick();
    clr = 1'b0;
    #2;
    chk_out("cleared", 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    #2;
    chk_out("cleared2", 0, 0, 0, 0, 0, 0);

    // ---------------- selection order ----------------
    do_reset();
`ifdef RS_AGE_ORDER_EN
    rob_head = 4'd6;
`endif
    idle_inputs(); set_disp(OP_ADD, 0, 70, 1, 0, 1, 0, 7); tick();
    idle_inputs(); set_disp(OP_ADD, 0, 0, 2, 0, 1, 0, 8); tick();
    idle_inputs(); set_disp(OP_ADD, 0, 0, 2, 0, 1, 0, 9); tick();
    idle_inputs(); set_disp(OP_ADD, 0, 60, 1, 0, 1, 0, 6); tick();
    idle_inputs();
    bus.cdb_alu_ready = 1'b1; bus.cdb_alu_rob_id = 4'd1; bus.cdb_alu_result = 32'd100;
    #2;
    chk_out("order_wait", 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    #2;
`ifdef RS_AGE_ORDER_EN
    chk_out("order_first", 0, 1, OP_ADD, 32'd100, 32'd60, 6);
    tick(); #2;
    chk_out("order_second", 0, 1, OP_ADD, 32'd100, 32'd70, 7);
`else
    chk_out("order_first", 0, 1, OP_ADD, 32'd100, 32'd70, 7);
    tick(); #2;
    chk_out("order_second", 0, 1, OP_ADD, 32'd100, 32'd60, 6);
`endif
    tick();
    #2;
    chk_out("order_done", 0, 0, 0, 0, 0, 0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
`ifdef RS_AGE_ORDER_EN
      rob_head = 4'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 1) == 1)
        set_disp(int'($urandom_range(0, 15)), int'($urandom), int'($urandom),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 15)));
      bus.cdb_alu_ready  = ($urandom_range(0, 2) == 0);
      bus.cdb_alu_rob_id = 4'($urandom_range(0, 15));
      bus.cdb_alu_result = $urandom;
      bus.cdb_lsb_ready  = ($urandom_range(0, 2) == 0);
      bus.cdb_lsb_rob_id = 4'($urandom_range(0, 15));
      bus.cdb_lsb_result = $urandom;
      if (bus.cdb_alu_ready && bus.cdb_lsb_ready && bus.cdb_alu_rob_id == bus.cdb_lsb_rob_id)
        bus.cdb_lsb_rob_id = bus.cdb_alu_rob_id + 4'd1;
      #2;
      exp_i = m_pick();
      ei    = (exp_i < 0) ? 0 : exp_i;
      ereq  = (rdy && !clr && exp_i >= 0) ? 1 : 0;
      chk_out("rand", int'(m_is_full()), ereq, m_typ[ei], m_vj[ei], m_vk[ei], m_rob[ei]);
      m_edge();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
